// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// Register-address width and controller state encoding.
package pipe_ctrl_pkg;
    localparam int REG_ADDR_W = 3;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_HALT     = 3'd3,
        ST_ERR      = 3'd4
    } state_t;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID-stage source that depends on
// the load currently in EX. R0 is compared like any other register.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  load_use
);
    logic [REG_ADDR_W-1:0] src [2];
    logic [1:0]            used;
    logic [1:0]            match;

    assign src[0] = id_rs1;
    assign src[1] = id_rs2;
    assign used   = {id_use_rs2, id_use_rs1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign match[gi] = used[gi] & (src[gi] == ex_rd);
        end
    endgenerate

    assign load_use = ex_mem_read & (|match);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline: stage enables/flushes for
// load-use, taken branches, memory waits, drain-then-halt and timeout trap.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 15,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_access,
    input  logic                  mem_ready,
    input  logic                  halt_in,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_en,
    output logic                  idex_flush,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  memwb_bubble,
    output logic                  halted,
    output logic                  mem_error,
    output logic [15:0]           stall_cycles
);
    localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);
    localparam logic [2:0] DRAIN_W   = 3'(DRAIN_CYCLES);

    state_t      state_reg, state_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic [2:0]  drain_cnt_reg, drain_cnt_next;
    logic        mem_error_reg, mem_error_next;
    logic [15:0] stall_cnt_reg;
    logic        load_use;
    logic        mem_stall;
    logic        freeze;
    logic        count_stall;

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    assign mem_stall = mem_access & ~mem_ready;

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        mem_error_next = mem_error_reg;
        freeze         = 1'b0;
        halted         = 1'b0;
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        ifid_flush     = 1'b0;
        idex_en        = 1'b1;
        idex_flush     = 1'b0;
        exmem_en       = 1'b1;
        memwb_en       = 1'b1;
        memwb_bubble   = 1'b0;

        case (state_reg)
            ST_RUN: begin
                if (mem_stall) begin
                    freeze        = 1'b1;
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = 8'd1;
                end else if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (halt_in) begin
                    pc_en          = 1'b0;
                    ifid_flush     = 1'b1;
                    state_next     = ST_DRAIN;
                    drain_cnt_next = 3'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = 8'd0;
                end else if (wait_cnt_reg == TIMEOUT_W) begin
                    freeze         = 1'b1;
                    state_next     = ST_ERR;
                    mem_error_next = 1'b1;
                end else begin
                    freeze        = 1'b1;
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            ST_DRAIN: begin
                // A memory stall pauses the drain without consuming a drain cycle.
                if (mem_stall) begin
                    freeze = 1'b1;
                end else begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                    if (drain_cnt_reg == DRAIN_W) begin
                        state_next = ST_HALT;
                    end else begin
                        drain_cnt_next = drain_cnt_reg + 3'd1;
                    end
                end
            end
            ST_HALT: begin
                freeze = 1'b1;
                halted = 1'b1;
            end
            ST_ERR: begin
                freeze = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        if (freeze) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b0;
            idex_en      = 1'b0;
            idex_flush   = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            memwb_bubble = 1'b1;
        end
    end

    assign count_stall = ~pc_en & ((state_reg == ST_RUN) | (state_reg == ST_MEM_WAIT) |
                                   (state_reg == ST_DRAIN));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_RUN;
            wait_cnt_reg  <= 8'd0;
            drain_cnt_reg <= 3'd0;
            mem_error_reg <= 1'b0;
            stall_cnt_reg <= 16'd0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            mem_error_reg <= mem_error_next;
            if (count_stall && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    assign mem_error    = mem_error_reg;
    assign stall_cycles = stall_cnt_reg;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazards, branch priority, memory
// wait, timeout trap, reset recovery and drain-then-halt.
module tb_pipeline_hazard_ctrl;
    logic        clk;
    logic        reset;
    logic [2:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic        mem_access, mem_ready, halt_in;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic        exmem_en, memwb_en, memwb_bubble, halted, mem_error;
    logic [15:0] stall_cycles;
    logic [7:0]  ctrl;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_bubble}
    localparam logic [7:0] C_DEF = 8'b1101_0110;
    localparam logic [7:0] C_FRZ = 8'b0000_0001;
    localparam logic [7:0] C_BR  = 8'b1111_1110;
    localparam logic [7:0] C_LU  = 8'b0001_1110;
    localparam logic [7:0] C_HD  = 8'b0111_0110;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .DRAIN_CYCLES(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_access      (mem_access),
        .mem_ready       (mem_ready),
        .halt_in         (halt_in),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_flush      (idex_flush),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .memwb_bubble    (memwb_bubble),
        .halted          (halted),
        .mem_error       (mem_error),
        .stall_cycles    (stall_cycles)
    );

    assign ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_bubble};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 3'd0; id_rs2 = 3'd0; ex_rd = 3'd7;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; mem_access = 1'b0; mem_ready = 1'b0; halt_in = 1'b0;
    endtask

    // One transaction: let inputs settle, check the control vector, then clock.
    task automatic cyc(input string tag, input logic [7:0] exp);
        #1;
        check_val(tag, {24'd0, ctrl}, {24'd0, exp});
        $display("vec %-14s ctrl=%b exp=%b stall=%0d halted=%b err=%b",
                 tag, ctrl, exp, stall_cycles, halted, mem_error);
        tick();
    endtask

    task automatic set_lu(input logic [2:0] rd, input logic [2:0] rs1, input logic u1,
                          input logic [2:0] rs2, input logic u2, input logic ld);
        ex_rd = rd; id_rs1 = rs1; id_use_rs1 = u1;
        id_rs2 = rs2; id_use_rs2 = u2; ex_mem_read = ld;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        check_val("rst_ctrl", {24'd0, ctrl}, {24'd0, C_DEF});
        check_val("rst_stall", {16'd0, stall_cycles}, 32'd0);
        check_val("rst_halted", {31'd0, halted}, 32'd0);
        check_val("rst_err", {31'd0, mem_error}, 32'd0);
        reset = 1'b0;

        // Load-use hazards and their qualifiers
        set_lu(3'd3, 3'd3, 1'b1, 3'd1, 1'b0, 1'b1);
        cyc("lu_rs1", C_LU);
        idle();
        check_val("lu_rs1_stall", {16'd0, stall_cycles}, 32'd1);
        set_lu(3'd5, 3'd3, 1'b1, 3'd5, 1'b1, 1'b1);
        cyc("lu_rs2", C_LU);
        set_lu(3'd4, 3'd4, 1'b0, 3'd4, 1'b0, 1'b1);
        cyc("lu_unused", C_DEF);
        set_lu(3'd0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b1);
        cyc("lu_r0", C_LU);
        set_lu(3'd2, 3'd2, 1'b1, 3'd2, 1'b1, 1'b0);
        cyc("lu_noload", C_DEF);
        check_val("lu_stall", {16'd0, stall_cycles}, 32'd3);

        // Branch outranks a same-cycle load-use
        set_lu(3'd3, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1);
        ex_branch_taken = 1'b1;
        cyc("br_over_lu", C_BR);
        idle();
        check_val("br_stall", {16'd0, stall_cycles}, 32'd3);

        // Four-cycle memory wait then release
        mem_access = 1'b1;
        for (int i = 0; i < 4; i++) cyc("mw_freeze", C_FRZ);
        mem_ready = 1'b1;
        cyc("mw_release", C_DEF);
        idle();
        check_val("mw_stall", {16'd0, stall_cycles}, 32'd7);
        set_lu(3'd6, 3'd6, 1'b1, 3'd0, 1'b0, 1'b1);
        cyc("mw_back_run", C_LU);
        idle();
        check_val("mw_stall2", {16'd0, stall_cycles}, 32'd8);

        // Reset in the middle of a memory wait (wait_cnt reaches 5)
        mem_access = 1'b1;
        for (int i = 0; i < 5; i++) cyc("rw_freeze", C_FRZ);
        check_val("rw_stall", {16'd0, stall_cycles}, 32'd13);
        reset = 1'b1;
        cyc("rw_in_reset", C_FRZ);
        reset = 1'b0;
        idle();
        check_val("rw_stall_clr", {16'd0, stall_cycles}, 32'd0);
        cyc("rw_default", C_DEF);

        // Timeout: ERR after the 16th freeze cycle
        mem_access = 1'b1;
        for (int i = 0; i < 15; i++) cyc("to_freeze", C_FRZ);
        check_val("to_err_early", {31'd0, mem_error}, 32'd0);
        cyc("to_freeze16", C_FRZ);
        check_val("to_err_set", {31'd0, mem_error}, 32'd1);
        check_val("to_stall", {16'd0, stall_cycles}, 32'd16);
        mem_access = 1'b0;
        mem_ready = 1'b1;
        cyc("to_err_hold", C_FRZ);
        check_val("to_err_sticky", {31'd0, mem_error}, 32'd1);
        check_val("to_stall_hold", {16'd0, stall_cycles}, 32'd16);
        check_val("to_not_halted", {31'd0, halted}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        check_val("to_err_clr", {31'd0, mem_error}, 32'd0);
        check_val("to_stall_clr", {16'd0, stall_cycles}, 32'd0);
        cyc("to_run", C_DEF);

        // Halt drain with a two-cycle memory stall inside it
        halt_in = 1'b1;
        cyc("hd_halt_in", C_HD);
        halt_in = 1'b0;
        cyc("hd_drain1", C_HD);
        mem_access = 1'b1;
        cyc("hd_memstall", C_FRZ);
        cyc("hd_memstall", C_FRZ);
        idle();
        ex_branch_taken = 1'b1;
        cyc("hd_drain2_br", C_HD);
        ex_branch_taken = 1'b0;
        check_val("hd_not_yet", {31'd0, halted}, 32'd0);
        cyc("hd_drain3", C_HD);
        check_val("hd_halted", {31'd0, halted}, 32'd1);
        cyc("hd_halt_state", C_FRZ);
        check_val("hd_halted2", {31'd0, halted}, 32'd1);
        check_val("hd_stall", {16'd0, stall_cycles}, 32'd6);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
